// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_port_arbiter_pkg : shared state encodings and defaults for the arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_DATA    = 2'd1,
    ARB_INSTR   = 2'd2,
    ARB_DISCARD = 2'd3
  } arb_state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;
  localparam logic [3:0]  BE_WORD                = 4'hF;

endpackage

`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
// ============================================================================
// mem_arb_watchdog : busy-cycle counter with terminal-count flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arb_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign terminal = (count_q == W'(LIMIT));

  // Saturate at the limit so a stuck enable can never wrap past it.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !terminal) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one memory bus between fetch and data access
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        instr_stall,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_be,
  output logic [31:0] mem_rdata,
  output logic        memReady,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  arb_state_e  state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;

  logic        busy;
  logic        wd_terminal;
  logic        timeout;
  logic        done;
  logic [31:0] rsp_data;

  assign busy     = (state_q != ARB_IDLE);
  // A real ack in the terminal cycle still delivers its data without error.
  assign timeout  = busy & wd_terminal & ~bus_ack;
  assign done     = busy & (bus_ack | timeout);
  assign rsp_data = bus_ack ? bus_rdata : 32'h0;

  mem_arb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .clear    (state_d != state_q),
    .enable   (busy & ~bus_ack),
    .terminal (wd_terminal)
  );

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    case (state_q)
      ARB_IDLE: begin
        if (mem_req) begin
          state_d     = ARB_DATA;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          bus_be_d    = mem_be;
        end else if (if_req && !if_flush) begin
          state_d     = ARB_INSTR;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = 32'h0;
          bus_be_d    = BE_WORD;
        end
      end
      ARB_DATA: begin
        if (done) state_d = ARB_IDLE;
      end
      ARB_INSTR: begin
        if (if_flush) begin
          state_d = done ? ARB_IDLE : ARB_DISCARD;
        end else if (done) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_DISCARD: begin
        if (done) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (state_d == ARB_IDLE) bus_req_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_be_q    <= 4'h0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
    end
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_be      = bus_be_q;
  assign bus_err     = timeout;

  assign if_valid    = (state_q == ARB_INSTR) & done & ~if_flush;
  assign if_rdata    = rsp_data;
  assign instr_stall = if_req & ~if_valid;
  assign memReady    = ~mem_req | ((state_q == ARB_DATA) & done);
  assign mem_rdata   = rsp_data;

endmodule

`default_nettype wire
